int_wb_port_arbiter: RTL and testbench

//  Shares NUM_PORTS integer regfile write ports among NUM_REQ FU writeback requesters (ALU/BRU/MDU/LDU).

---
 rtl/int_wb_port_arbiter_pkg.sv | 18 +
 rtl/int_wb_port_arbiter_if.sv | 35 +++
 rtl/int_wb_port_arbiter_rr_multi_select.sv | 53 +++++
 rtl/int_wb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_int_wb_port_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/int_wb_port_arbiter_pkg.sv
// Shared types and default sizing for the integer writeback port arbiter.
//   valWBInfo_t    : one writeback record (rd_wen, physical dest index, result)
//   DEF_NUM_REQ    : default number of FU writeback requesters
//   DEF_NUM_PORTS  : default number of integer regfile write ports
package int_wb_port_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_PORTS = 2;
    localparam int IPRD_W        = 6;
    localparam int XLEN          = 32;

    typedef struct packed {
        logic              rd_wen;
        logic [IPRD_W-1:0] iprd_idx;
        logic [XLEN-1:0]   result;
    } valWBInfo_t;

endpackage

// File: rtl/int_wb_port_arbiter_if.sv
// Writeback bus between the FU requesters, the arbiter and the int regfile.
//   i_squash_vld : pipeline squash from commit
//   i_wb_vld     : per-requester result valid
//   o_wb_rdy     : per-requester ready (register-derived)
//   i_wb_info    : per-requester writeback record
//   o_port_vld   : per-port write enable
//   o_port_info  : per-port writeback record
//   o_conflict   : at least one candidate lost arbitration (perf)
// Modports: slave = arbiter, master = requester/regfile side.
interface int_wb_port_arbiter_if
    import int_wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) ();

    logic                         i_squash_vld;
    logic [NUM_REQ-1:0]           i_wb_vld;
    logic [NUM_REQ-1:0]           o_wb_rdy;
    valWBInfo_t [NUM_REQ-1:0]     i_wb_info;
    logic [NUM_PORTS-1:0]         o_port_vld;
    valWBInfo_t [NUM_PORTS-1:0]   o_port_info;
    logic                         o_conflict;

    modport slave (
        input  i_squash_vld, i_wb_vld, i_wb_info,
        output o_wb_rdy, o_port_vld, o_port_info, o_conflict
    );

    modport master (
        output i_squash_vld, i_wb_vld, i_wb_info,
        input  o_wb_rdy, o_port_vld, o_port_info, o_conflict
    );

endinterface

// File: rtl/int_wb_port_arbiter_rr_multi_select.sv
// Combinational round-robin picker of up to M requests out of N.
//   req_i      : request vector
//   ptr_i      : index scanned first
//   grant_o    : one-hot-per-winner grant vector
//   port_sel_o : requester index driving port k (k-th winner in scan order)
//   port_vld_o : port k has a winner
//   last_idx_o : index of the last winner (ptr_i when nobody wins)
module rr_multi_select #(
    parameter int N  = 4,
    parameter int M  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]         req_i,
    input  logic [IW-1:0]        ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [M-1:0][IW-1:0] port_sel_o,
    output logic [M-1:0]         port_vld_o,
    output logic [IW-1:0]        last_idx_o
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    always_comb begin
        int          cnt;
        logic [IW:0] sum;
        logic [IW-1:0] idx;
        grant_o    = '0;
        port_sel_o = '0;
        port_vld_o = '0;
        last_idx_o = ptr_i;
        cnt        = 0;
        for (int j = 0; j < N; j++) begin
            // explicit modulo so N need not be a power of two
            sum = {1'b0, ptr_i} + (IW+1)'(j);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[IW-1:0];
            if (req_i[idx] && cnt < M) begin
                grant_o[idx] = 1'b1;
                for (int k = 0; k < M; k++) begin
                    if (cnt == k) begin
                        port_sel_o[k] = idx;
                        port_vld_o[k] = 1'b1;
                    end
                end
                last_idx_o = idx;
                cnt++;
            end
        end
    end

endmodule

// File: rtl/int_wb_port_arbiter.sv
// Shares NUM_PORTS integer regfile write ports among NUM_REQ FU writeback
// requesters. Round-robin, one-entry hold buffer per requester, registered
// outputs, squash drops buffered and newly presented writes.
//   clk : core clock
//   rst : asynchronous reset, active-low
//   bus : writeback bus (slave side)
module int_wb_port_arbiter
    import int_wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    int_wb_port_arbiter_if.slave bus
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]           buf_vld_q, buf_vld_d;
    valWBInfo_t                   buf_info_q [NUM_REQ];
    valWBInfo_t                   buf_info_d [NUM_REQ];
    logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]         port_vld_q, port_vld_d;
    valWBInfo_t [NUM_PORTS-1:0]   port_info_q, port_info_d;
    logic                         conflict_q, conflict_d;

    logic [NUM_REQ-1:0]           accept, req, grant, lose;
    valWBInfo_t                   cand_info [NUM_REQ];
    logic [NUM_PORTS-1:0][IW-1:0] sel_idx;
    logic [NUM_PORTS-1:0]         sel_vld;
    logic [IW-1:0]                last_idx;
    logic                         dup_iprd;

    assign accept = bus.i_wb_vld & ~buf_vld_q;

    // A buffered entry always has priority over a new input on the same requester
    // (the requester is not ready while its buffer is full anyway).
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_info[i] = buf_vld_q[i] ? buf_info_q[i] : bus.i_wb_info[i];
            req[i]       = (buf_vld_q[i] | accept[i]) & cand_info[i].rd_wen;
        end
    end

    rr_multi_select #(
        .N  (NUM_REQ),
        .M  (NUM_PORTS),
        .IW (IW)
    ) u_sel (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .port_sel_o (sel_idx),
        .port_vld_o (sel_vld),
        .last_idx_o (last_idx)
    );

    // Every losing candidate ends up buffered: a buffered loser stays, an accepted
    // loser is latched. Anything else (winners, rd_wen==0) leaves the buffer empty.
    assign lose = req & ~grant;

    always_comb begin
        if (bus.i_squash_vld) begin
            buf_vld_d  = '0;
            rr_ptr_d   = '0;
            port_vld_d = '0;
            conflict_d = 1'b0;
        end else begin
            buf_vld_d  = lose;
            port_vld_d = sel_vld;
            conflict_d = |lose;
            if (|sel_vld) begin
                rr_ptr_d = (last_idx == LAST_REQ) ? '0 : last_idx + IW'(1);
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            buf_info_d[i] = (lose[i] && !bus.i_squash_vld) ? cand_info[i] : buf_info_q[i];
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            port_info_d[k] = (sel_vld[k] && !bus.i_squash_vld) ? cand_info[sel_idx[k]]
                                                                : port_info_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld_q   <= '0;
            buf_info_q  <= '{default: '0};
            rr_ptr_q    <= '0;
            port_vld_q  <= '0;
            port_info_q <= '0;
            conflict_q  <= 1'b0;
        end else begin
            buf_vld_q   <= buf_vld_d;
            buf_info_q  <= buf_info_d;
            rr_ptr_q    <= rr_ptr_d;
            port_vld_q  <= port_vld_d;
            port_info_q <= port_info_d;
            conflict_q  <= conflict_d;
        end
    end

    assign bus.o_wb_rdy    = ~buf_vld_q;
    assign bus.o_port_vld  = port_vld_q;
    assign bus.o_port_info = port_info_q;
    assign bus.o_conflict  = conflict_q;

    // Upstream guarantees distinct destinations among live writes in a cycle.
    always_comb begin
        dup_iprd = 1'b0;
        for (int a = 0; a < NUM_REQ; a++) begin
            for (int b = a + 1; b < NUM_REQ; b++) begin
                if (req[a] && req[b] && cand_info[a].iprd_idx == cand_info[b].iprd_idx) begin
                    dup_iprd = 1'b1;
                end
            end
        end
    end

    a_no_dup_iprd : assert property (@(posedge clk) disable iff (!rst)
        !(dup_iprd && !bus.i_squash_vld));

endmodule

// File: tb/tb_int_wb_port_arbiter.sv
module tb_int_wb_port_arbiter;
    import int_wb_port_arbiter_pkg::*;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                squash;
    logic [NR-1:0]       vld;
    valWBInfo_t [NR-1:0] info;

    int_wb_port_arbiter_if #(.NUM_REQ(NR), .NUM_PORTS(2)) bus2 ();
    int_wb_port_arbiter_if #(.NUM_REQ(NR), .NUM_PORTS(1)) bus1 ();

    assign bus2.i_squash_vld = squash;
    assign bus2.i_wb_vld     = vld;
    assign bus2.i_wb_info    = info;
    assign bus1.i_squash_vld = squash;
    assign bus1.i_wb_vld     = vld;
    assign bus1.i_wb_info    = info;

    int_wb_port_arbiter #(.NUM_REQ(NR), .NUM_PORTS(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int_wb_port_arbiter #(.NUM_REQ(NR), .NUM_PORTS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_pass;
    int n_total;
    int cyc;

    // Reference model: per DUT (0 = two ports, 1 = one port) a set of waiting
    // records, a scan start index, and the outputs expected after the next edge.
    logic       pend_v [2][NR];
    valWBInfo_t pend_i [2][NR];
    int         ptr_m  [2];
    logic [1:0] exp_pv [2];
    valWBInfo_t exp_pi [2][2];
    logic       exp_cf [2];

    typedef struct {
        logic [3:0] vld;
        logic [3:0] wen;
        logic       sq;
        logic [3:0] rdy2;
        logic [3:0] rdy1;
        logic [1:0] pv2;
        int         p0_2;
        int         p1_2;
        logic       cf2;
        logic       pv1;
        int         p0_1;
        logic       cf1;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        n_total++;
        if (act === req_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    task automatic set_info(input logic [3:0] wen, input int tag);
        for (int i = 0; i < NR; i++) begin
            info[i].rd_wen   = wen[i];
            info[i].iprd_idx = {4'(tag), 2'(i)};
            info[i].result   = $urandom;
        end
    endtask

    function automatic logic [3:0] exp_rdy(input int d);
        logic [3:0] r;
        for (int i = 0; i < NR; i++) r[i] = ~pend_v[d][i];
        return r;
    endfunction

    task automatic model_step(input int d);
        int m;
        int won;
        int last;
        valWBInfo_t c;
        m = (d == 0) ? 2 : 1;
        won = 0;
        last = -1;
        exp_pv[d] = '0;
        exp_cf[d] = 1'b0;
        if (squash) begin
            for (int r = 0; r < NR; r++) pend_v[d][r] = 1'b0;
            ptr_m[d] = 0;
            return;
        end
        for (int k = 0; k < NR; k++) begin
            int r;
            r = (ptr_m[d] + k) % NR;
            if (pend_v[d][r]) c = pend_i[d][r];
            else if (vld[r]) c = info[r];
            else continue;
            if (!c.rd_wen) continue;
            if (won < m) begin
                exp_pv[d][won] = 1'b1;
                exp_pi[d][won] = c;
                won++;
                last = r;
                pend_v[d][r] = 1'b0;
            end else begin
                pend_v[d][r] = 1'b1;
                pend_i[d][r] = c;
                exp_cf[d] = 1'b1;
            end
        end
        if (last >= 0) ptr_m[d] = (last + 1) % NR;
    endtask

    task automatic check_out(input int d, input logic [1:0] pv, input valWBInfo_t p0,
                             input valWBInfo_t p1, input logic cf);
        check($sformatf("m%0d port_vld c%0d", d, cyc), pv, exp_pv[d]);
        if (exp_pv[d][0]) check($sformatf("m%0d port0 c%0d", d, cyc), p0, exp_pi[d][0]);
        if (exp_pv[d][1]) check($sformatf("m%0d port1 c%0d", d, cyc), p1, exp_pi[d][1]);
        check($sformatf("m%0d conflict c%0d", d, cyc), cf, exp_cf[d]);
    endtask

    // Inputs are already applied; check ready, predict, clock, check registered outputs.
    task automatic step();
        check($sformatf("m0 rdy c%0d", cyc), bus2.o_wb_rdy, exp_rdy(0));
        check($sformatf("m1 rdy c%0d", cyc), bus1.o_wb_rdy, exp_rdy(1));
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        check_out(0, bus2.o_port_vld, bus2.o_port_info[0], bus2.o_port_info[1], bus2.o_conflict);
        check_out(1, {1'b0, bus1.o_port_vld}, bus1.o_port_info[0], '0, bus1.o_conflict);
    endtask

    initial begin
        vec_t tv[$];
        int   streak[NR];
        int   maxw;
        int   r2_at;

        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        for (int d = 0; d < 2; d++) begin
            ptr_m[d] = 0;
            for (int r = 0; r < NR; r++) pend_v[d][r] = 1'b0;
        end

        //                vld      wen      sq    rdy2     rdy1     pv2   p0 p1 cf2   pv1  p0 cf1
        tv.push_back(vec_t'{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b11, 0, 1, 1'b1, 1'b1, 0, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b0011, 4'b0001, 2'b11, 2, 3, 1'b0, 1'b1, 1, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0011, 2'b00, -1, -1, 1'b0, 1'b1, 2, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0111, 2'b00, -1, -1, 1'b0, 1'b1, 3, 1'b0});
        tv.push_back(vec_t'{4'b0111, 4'b0101, 1'b0, 4'b1111, 4'b1111, 2'b11, 0, 2, 1'b0, 1'b1, 0, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1011, 2'b00, -1, -1, 1'b0, 1'b1, 2, 1'b0});
        tv.push_back(vec_t'{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b11, 3, 0, 1'b1, 1'b1, 3, 1'b1});
        tv.push_back(vec_t'{4'b0001, 4'b1111, 1'b1, 4'b1001, 4'b1000, 2'b00, -1, -1, 1'b0, 1'b0, -1, 1'b0});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b00, -1, -1, 1'b0, 1'b0, -1, 1'b0});
        tv.push_back(vec_t'{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b11, 0, 1, 1'b1, 1'b1, 0, 1'b1});
        tv.push_back(vec_t'{4'b0001, 4'b1111, 1'b1, 4'b0011, 4'b0001, 2'b00, -1, -1, 1'b0, 1'b0, -1, 1'b0});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b00, -1, -1, 1'b0, 1'b0, -1, 1'b0});
        tv.push_back(vec_t'{4'b0100, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b01, 2, -1, 1'b0, 1'b1, 2, 1'b0});
        tv.push_back(vec_t'{4'b1001, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b11, 3, 0, 1'b0, 1'b1, 3, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1110, 2'b00, -1, -1, 1'b0, 1'b1, 0, 1'b0});
        tv.push_back(vec_t'{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 2'b11, 1, 2, 1'b1, 1'b1, 1, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b0110, 4'b0010, 2'b11, 3, 0, 1'b0, 1'b1, 2, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0110, 2'b00, -1, -1, 1'b0, 1'b1, 3, 1'b1});
        tv.push_back(vec_t'{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1110, 2'b00, -1, -1, 1'b0, 1'b1, 0, 1'b0});

        rst    = 1'b0;
        squash = 1'b0;
        vld    = 4'b1111;
        set_info(4'b1111, 0);
        #12;
        check("reset m0 port_vld", bus2.o_port_vld, 2'b00);
        check("reset m0 rdy", bus2.o_wb_rdy, 4'b1111);
        check("reset m0 conflict", bus2.o_conflict, 1'b0);
        check("reset m0 port0 info", bus2.o_port_info[0], '0);
        check("reset m1 port_vld", bus1.o_port_vld, 1'b0);
        check("reset m1 rdy", bus1.o_wb_rdy, 4'b1111);
        check("reset m1 conflict", bus1.o_conflict, 1'b0);
        rst = 1'b1;

        for (int n = 0; n < tv.size(); n++) begin
            vld    = tv[n].vld;
            squash = tv[n].sq;
            set_info(tv[n].wen, n);
            check($sformatf("v%0d rdy2", n), bus2.o_wb_rdy, tv[n].rdy2);
            check($sformatf("v%0d rdy1", n), bus1.o_wb_rdy, tv[n].rdy1);
            step();
            check($sformatf("v%0d pvld2", n), bus2.o_port_vld, tv[n].pv2);
            if (tv[n].pv2[0]) check($sformatf("v%0d p0 src2", n), bus2.o_port_info[0].iprd_idx[1:0], 64'(tv[n].p0_2));
            if (tv[n].pv2[1]) check($sformatf("v%0d p1 src2", n), bus2.o_port_info[1].iprd_idx[1:0], 64'(tv[n].p1_2));
            check($sformatf("v%0d conf2", n), bus2.o_conflict, tv[n].cf2);
            check($sformatf("v%0d pvld1", n), bus1.o_port_vld, tv[n].pv1);
            if (tv[n].pv1) check($sformatf("v%0d p0 src1", n), bus1.o_port_info[0].iprd_idx[1:0], 64'(tv[n].p0_1));
            check($sformatf("v%0d conf1", n), bus1.o_conflict, tv[n].cf1);
        end

        // Fairness on the single-port instance: r0/r1 always valid, r2 once.
        maxw  = 0;
        r2_at = -1;
        for (int i = 0; i < NR; i++) streak[i] = 0;
        for (int c = 0; c < 10; c++) begin
            vld    = (c == 1) ? 4'b0111 : 4'b0011;
            squash = 1'b0;
            set_info(4'b1111, c);
            for (int i = 0; i < NR; i++) begin
                streak[i] = bus1.o_wb_rdy[i] ? 0 : streak[i] + 1;
                if (streak[i] > maxw) maxw = streak[i];
            end
            step();
            if (r2_at < 0 && bus1.o_port_vld[0] && bus1.o_port_info[0].iprd_idx[1:0] == 2'd2) r2_at = c;
        end
        check("fair r2 granted within 4", (r2_at >= 1 && r2_at <= 4), 1'b1);
        check("fair max wait le 2", (maxw <= 2), 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [3:0] wen;
            for (int i = 0; i < NR; i++) wen[i] = ($urandom_range(0, 4) != 0);
            vld    = 4'($urandom);
            squash = ($urandom_range(0, 19) == 0);
            set_info(wen, $urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
